// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential ALU/divider block.
package alu_pkg;

  localparam int DATA_W = 4;

  typedef logic [1:0] opcode_t;
  localparam opcode_t OP_PASS_A = 2'b00;
  localparam opcode_t OP_PASS_B = 2'b01;
  localparam opcode_t OP_QUOT   = 2'b10;
  localparam opcode_t OP_REM    = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DIV  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between a requester and the sequential ALU.
interface alu_seq_ctrl_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] inputA;
  logic [DATA_W-1:0] inputB;
  opcode_t           opcode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              div_zero;
  logic              busy;

  modport master (
    output in_valid, inputA, inputB, opcode, out_ready,
    input  in_ready, out_valid, result, div_zero, busy
  );

  modport slave (
    input  in_valid, inputA, inputB, opcode, out_ready,
    output in_ready, out_valid, result, div_zero, busy
  );

endinterface

// File: rtl/alu_seq_ctrl_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import alu_pkg::*;
(
  input  logic [DATA_W:0]   pr_in,
  input  logic              a_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   pr_out,
  output logic              q_bit
);

  logic [DATA_W+1:0] shifted;

  // pr_in is always below the divisor, so the shifted value never exceeds 2*15+1.
  assign shifted = {pr_in, a_bit};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign pr_out  = q_bit ? (shifted[DATA_W:0] - {1'b0, divisor}) : shifted[DATA_W:0];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU: pass A/B in one cycle, quotient/remainder via a 4-step restoring divider.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.slave  bus
);

  state_t            state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  opcode_t           op_reg;
  logic [DATA_W-1:0] q_reg;
  logic [DATA_W:0]   pr_reg;
  logic [DATA_W-1:0] result_reg;
  logic              dz_reg;

  logic [DATA_W:0]   pr_next;
  logic              q_bit;
  logic [DATA_W-1:0] q_next;

  div_step u_div_step (
    .pr_in   (pr_reg),
    .a_bit   (a_reg[cnt]),
    .divisor (b_reg),
    .pr_out  (pr_next),
    .q_bit   (q_bit)
  );

  assign q_next = {q_reg[DATA_W-2:0], q_bit};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_PASS_A;
      q_reg      <= '0;
      pr_reg     <= '0;
      result_reg <= '0;
      dz_reg     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg  <= bus.inputA;
            b_reg  <= bus.inputB;
            op_reg <= bus.opcode;
            if (!bus.opcode[1]) begin
              result_reg <= (bus.opcode == OP_PASS_B) ? bus.inputB : bus.inputA;
              dz_reg     <= 1'b0;
              state      <= ST_DONE;
            end else if (bus.inputB == '0) begin
              // Divide by zero: saturated quotient, remainder is the dividend.
              q_reg      <= '1;
              pr_reg     <= {1'b0, bus.inputA};
              result_reg <= (bus.opcode == OP_REM) ? bus.inputA : '1;
              dz_reg     <= 1'b1;
              state      <= ST_DONE;
            end else begin
              q_reg  <= '0;
              pr_reg <= '0;
              cnt    <= 2'd3;
              dz_reg <= 1'b0;
              state  <= ST_DIV;
            end
          end
        end

        ST_DIV: begin
          pr_reg <= pr_next;
          q_reg  <= q_next;
          if (cnt == 2'd0) begin
            result_reg <= (op_reg == OP_REM) ? pr_next[DATA_W-1:0] : q_next;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.result    = result_reg;
  assign bus.div_zero  = dz_reg;

endmodule
